// File: rtl/majority_serial_ctrl.sv
// Sequenced majority voter: counts the ones of an N-bit word B bits per cycle with one
// shared popcount slice and reports majority, tie and ones-count over valid/ready.
module majority_serial_ctrl #(
    parameter int unsigned N = 32,
    parameter int unsigned B = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [N-1:0]             in_seq_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_major_o,
    output logic                     out_tie_o,
    output logic [$clog2(N+1)-1:0]   out_ones_o
);

    localparam int unsigned BEATS = N / B;
    localparam int unsigned W     = $clog2(N + 1);
    localparam int unsigned BW    = $clog2(BEATS + 1);

    if (N < 2 || B < 1 || B > N || (N % B) != 0) begin : g_bad_params
        $error("majority_serial_ctrl: need N >= 2, 1 <= B <= N and N %% B == 0");
    end

    typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  ones_q, ones_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          major_q, major_d;
    logic          tie_q, tie_d;

    logic [W-1:0]  slice_ones;
    logic [W-1:0]  sum;
    logic [W:0]    twice;

    always_comb begin
        slice_ones = '0;
        for (int i = 0; i < int'(B); i++) begin
            slice_ones = slice_ones + W'(shreg_q[i]);
        end
    end

    // acc + slice never exceeds N, so W bits suffice; the vote compares in W+1 bits.
    assign sum   = acc_q + slice_ones;
    assign twice = {sum, 1'b0};

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        ones_d  = ones_q;
        major_d = major_q;
        tie_d   = tie_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    shreg_d = in_seq_i;
                    acc_d   = '0;
                    beat_d  = '0;
                    state_d = StCount;
                end
            end
            StCount: begin
                acc_d   = sum;
                shreg_d = shreg_q >> B;
                beat_d  = beat_q + 1'b1;
                if (beat_q == BW'(BEATS - 1)) begin
                    ones_d  = sum;
                    major_d = twice > (W + 1)'(N);
                    tie_d   = twice == (W + 1)'(N);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shreg_q <= '0;
            acc_q   <= '0;
            beat_q  <= '0;
            ones_q  <= '0;
            major_q <= 1'b0;
            tie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            ones_q  <= ones_d;
            major_q <= major_d;
            tie_q   <= tie_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign out_major_o = major_q;
    assign out_tie_o   = tie_q;
    assign out_ones_o  = ones_q;

endmodule

// File: tb/tb_majority_serial_ctrl.sv
// Bench for majority_serial_ctrl: scoreboard-checked main instance (N=32, B=4) plus
// three parameter-sweep instances (B=1, B=32, N=7/B=7).
module tb_majority_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0] in_seq = '0;
    logic        out_major, out_tie;
    logic [5:0]  out_ones;

    logic        s_valid [3];
    logic [31:0] s_seq [3];
    logic        s_ready [3];
    logic        s_ov [3];
    logic        s_maj [3];
    logic        s_tie [3];
    logic [5:0]  ones_b1, ones_b32;
    logic [2:0]  ones_n7;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [5:0] ones;
        logic       major;
        logic       tie;
    } exp_t;
    exp_t sb [$];

    majority_serial_ctrl #(.N(32), .B(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_seq_i(in_seq), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_major_o(out_major), .out_tie_o(out_tie), .out_ones_o(out_ones)
    );
    majority_serial_ctrl #(.N(32), .B(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(s_valid[0]), .in_ready_o(s_ready[0]),
        .in_seq_i(s_seq[0]), .out_valid_o(s_ov[0]), .out_ready_i(1'b1),
        .out_major_o(s_maj[0]), .out_tie_o(s_tie[0]), .out_ones_o(ones_b1)
    );
    majority_serial_ctrl #(.N(32), .B(32)) dut_b32 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(s_valid[1]), .in_ready_o(s_ready[1]),
        .in_seq_i(s_seq[1]), .out_valid_o(s_ov[1]), .out_ready_i(1'b1),
        .out_major_o(s_maj[1]), .out_tie_o(s_tie[1]), .out_ones_o(ones_b32)
    );
    majority_serial_ctrl #(.N(7), .B(7)) dut_n7 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(s_valid[2]), .in_ready_o(s_ready[2]),
        .in_seq_i(s_seq[2][6:0]), .out_valid_o(s_ov[2]), .out_ready_i(1'b1),
        .out_major_o(s_maj[2]), .out_tie_o(s_tie[2]), .out_ones_o(ones_n7)
    );

    function automatic exp_t model32(input logic [31:0] w);
        exp_t e;
        int   c;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(w[i]);
        e.ones  = 6'(c);
        e.major = (c > 16);
        e.tie   = (c == 16);
        return e;
    endfunction

    // Every completed output handshake is matched against the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: got ones=%0d major=%0b tie=%0b, none expected",
                         out_ones, out_major, out_tie);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({out_ones, out_major, out_tie} !== {e.ones, e.major, e.tie}) begin
                    errors++;
                    $display("FAIL scoreboard_result: got ones=%0d major=%0b tie=%0b, want ones=%0d major=%0b tie=%0b",
                             out_ones, out_major, out_tie, e.ones, e.major, e.tie);
                end
            end
        end
    end

    // Offers one word to the main DUT; returns edges until out_valid (or -1) and
    // whether in_ready stayed low from accept until out_valid.
    task automatic send_word(input logic [31:0] w, output int lat, output bit rdy_low);
        int guard;
        guard = 0;
        while (!in_ready && guard < 64) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL idle_timeout: in_ready=%0b, required 1 within 64 cycles", in_ready);
        end
        in_valid = 1'b1;
        in_seq   = w;
        @(posedge clk); #1;
        sb.push_back(model32(w));
        in_valid = 1'b0;
        in_seq   = 'x;
        lat      = -1;
        rdy_low  = 1'b1;
        for (int k = 1; k <= 64 && lat < 0; k++) begin
            if (in_ready) rdy_low = 1'b0;
            @(posedge clk); #1;
            if (out_valid) lat = k;
        end
        if (in_ready) rdy_low = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (sb.size() != 0 || !in_ready); k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({in_ready, out_valid, out_major, out_tie, out_ones} !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%0b vld=%0b maj=%0b tie=%0b ones=%0d, want 1 0 0 0 0",
                     in_ready, out_valid, out_major, out_tie, out_ones);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%0b vld=%0b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_full_ones();
        int lat;
        bit rl;
        out_ready = 1'b1;
        send_word(32'hFFFF_FFFF, lat, rl);
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL full_latency: got %0d edges, want 8", lat);
        end
        checks++;
        if (!rl) begin
            errors++;
            $display("FAIL full_ready_low: in_ready rose during COUNT/DONE, want 0 throughout");
        end
        checks++;
        if (out_ones !== 6'd32 || out_major !== 1'b1 || out_tie !== 1'b0) begin
            errors++;
            $display("FAIL full_values: got ones=%0d maj=%0b tie=%0b, want 32 1 0",
                     out_ones, out_major, out_tie);
        end
        drain();
    endtask

    task automatic test_patterns();
        logic [31:0] pats [4];
        int lat;
        bit rl;
        pats[0] = 32'h0000_FFFF;
        pats[1] = 32'h0001_FFFF;
        pats[2] = 32'h0000_0000;
        pats[3] = 32'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            send_word(pats[i], lat, rl);
            checks++;
            if (lat != 8 || !rl) begin
                errors++;
                $display("FAIL pattern_timing[%0d]: got lat=%0d rdy_low=%0b, want 8 1", i, lat, rl);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit rl;
        exp_t e;
        e = model32(32'h1234_5678);
        out_ready = 1'b0;
        send_word(32'h1234_5678, lat, rl);
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL bp_latency: got %0d, want 8", lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, out_ones, out_major, out_tie} !== {1'b1, 1'b0, e.ones, e.major, e.tie}) begin
                errors++;
                $display("FAIL bp_stable[%0d]: got vld=%0b rdy=%0b ones=%0d maj=%0b tie=%0b, want 1 0 %0d %0b %0b",
                         c, out_valid, in_ready, out_ones, out_major, out_tie, e.ones, e.major, e.tie);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got vld=%0b rdy=%0b, want 0 1", out_valid, in_ready);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [3];
        int t [3];
        int idx;
        bit acc_now;
        w[0] = 32'hAAAA_AAAA;
        w[1] = 32'h8000_0001;
        w[2] = 32'hFFFF_FFFE;
        idx = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_seq = w[0];
        for (int c = 0; c < 100 && idx < 3; c++) begin
            acc_now = in_ready;
            if (acc_now) begin
                sb.push_back(model32(w[idx]));
                t[idx] = c;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                idx++;
                if (idx < 3) in_seq = w[idx];
            end
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d accepts, want 3", idx);
        end else begin
            checks++;
            if (t[1] - t[0] != 10 || t[2] - t[1] != 10) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d/%0d cycles, want 10/10", t[1] - t[0], t[2] - t[1]);
            end
        end
        drain();
    endtask

    task automatic test_abort();
        int lat;
        bit rl;
        in_valid = 1'b1;
        in_seq = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ones !== 6'd0) begin
            errors++;
            $display("FAIL abort_reset: got vld=%0b rdy=%0b ones=%0d, want 0 1 0",
                     out_valid, in_ready, out_ones);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(32'h0F0F_0F0F, lat, rl);
        checks++;
        if (lat != 8 || out_tie !== 1'b1 || out_ones !== 6'd16) begin
            errors++;
            $display("FAIL abort_recover: got lat=%0d ones=%0d tie=%0b, want 8 16 1", lat, out_ones, out_tie);
        end
        drain();
    endtask

    task automatic run_sweep(input int k, input logic [31:0] w, output int lat,
                             output logic [5:0] ones, output logic maj, output logic tie);
        s_valid[k] = 1'b1;
        s_seq[k]   = w;
        @(posedge clk); #1;
        s_valid[k] = 1'b0;
        lat  = -1;
        ones = '0;
        maj  = 1'b0;
        tie  = 1'b0;
        for (int e = 1; e <= 64 && lat < 0; e++) begin
            @(posedge clk); #1;
            if (s_ov[k]) begin
                lat  = e;
                ones = (k == 0) ? ones_b1 : (k == 1) ? ones_b32 : {3'b000, ones_n7};
                maj  = s_maj[k];
                tie  = s_tie[k];
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep();
        int beats [3];
        int nbits [3];
        logic [31:0] w;
        int lat, c;
        logic [5:0] ones;
        logic maj, tie;
        beats[0] = 32; beats[1] = 1; beats[2] = 1;
        nbits[0] = 32; nbits[1] = 32; nbits[2] = 7;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 6; j++) begin
                w = (j == 0) ? 32'h0000_0071 : (j == 1) ? 32'h0000_FFFF : $urandom;
                c = 0;
                for (int i = 0; i < nbits[k]; i++) c += int'(w[i]);
                run_sweep(k, w, lat, ones, maj, tie);
                checks++;
                if (lat != beats[k] || int'(ones) != c || maj !== (2 * c > nbits[k])
                    || tie !== (2 * c == nbits[k])) begin
                    errors++;
                    $display("FAIL sweep[%0d][%0d]: got lat=%0d ones=%0d maj=%0b tie=%0b, want %0d %0d %0b %0b",
                             k, j, lat, ones, maj, tie, beats[k], c, 2 * c > nbits[k], 2 * c == nbits[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        int lat;
        bit rl;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 3))
                0: w = $urandom;
                1: w = $urandom & $urandom;
                2: w = $urandom | $urandom;
                default: w = {16'h0000, 16'hFFFF} ^ ($urandom & 32'h0001_0001);
            endcase
            out_ready = 1'b1;
            send_word(w, lat, rl);
            if (lat != 8) begin
                checks++;
                errors++;
                $display("FAIL random_latency[%0d]: got %0d, want 8", n, lat);
            end
            for (int k = 0; k < 50 && out_valid; k++) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        drain();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            s_valid[k] = 1'b0;
            s_seq[k]   = '0;
        end
        test_reset();
        test_full_ones();
        test_patterns();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_sweep();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
